// File: rtl/pkt_pkg.sv
// Shared types for the packet encoder/decoder pair: opcode codes and encoder FSM states.
// The CHK state exists only when PKT_ENC_CHKSUM_EN is defined.
package pkt_pkg;

  localparam int OP_NUM   = 5;
  localparam int NIBBLE_W = 4;

  typedef enum logic [3:0] {
    LOAD    = 4'd0,
    STORE   = 4'd1,
    JUMP    = 4'd2,
    ALU_OP  = 4'd3,
    INVALID = 4'd4
  } opcode_e;

`ifdef PKT_ENC_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_e;
`else
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;
`endif

endpackage

// File: rtl/pkt_encoder_if.sv
// Request and nibble-stream signals of the packet encoder.
// slave = encoder side, master = issue logic / link sink side.
interface pkt_encoder_if #(
  parameter int PAYLOAD_W = 8,
  parameter int CNT_W     = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_req;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [3:0]           tx_data;
  logic                 tx_last;
  logic                 enc_err;
  logic [CNT_W-1:0]     pkt_cnt;

  modport slave (
    input  in_valid, in_req, in_payload, tx_ready,
    output in_ready, tx_valid, tx_data, tx_last, enc_err, pkt_cnt
  );

  modport master (
    output in_valid, in_req, in_payload, tx_ready,
    input  in_ready, tx_valid, tx_data, tx_last, enc_err, pkt_cnt
  );
endinterface

// File: rtl/pkt_onehot_enc.sv
// One-hot request to opcode. Anything other than exactly one set bit maps to INVALID
// and is flagged as malformed; an explicit INVALID request is not malformed.
module pkt_onehot_enc
  import pkt_pkg::*;
(
  input  logic [OP_NUM-1:0] req_i,
  output opcode_e           op_o,
  output logic              bad_o
);

  always_comb begin
    op_o  = INVALID;
    bad_o = 1'b1;
    case (req_i)
      5'b00001: begin op_o = LOAD;    bad_o = 1'b0; end
      5'b00010: begin op_o = STORE;   bad_o = 1'b0; end
      5'b00100: begin op_o = JUMP;    bad_o = 1'b0; end
      5'b01000: begin op_o = ALU_OP;  bad_o = 1'b0; end
      5'b10000: begin op_o = INVALID; bad_o = 1'b0; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/pkt_encoder.sv
// Packet encoder: captures a one-hot request, emits header nibble then payload nibbles LSN first.
// Define PKT_ENC_CHKSUM_EN to append an XOR checksum nibble as the final beat.
module pkt_encoder
  import pkt_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  pkt_encoder_if.slave bus
);

  localparam int NIB    = PAYLOAD_W / NIBBLE_W;
  localparam int BEAT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NIB - 1);

  state_e                state_q, state_d;
  opcode_e               op_q, op_d;
  logic [PAYLOAD_W-1:0]  pay_q, pay_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  opcode_e               req_op;
  logic                  req_bad;
  logic [3:0]            pay_nib;
  logic                  last_nib;

  pkt_onehot_enc u_enc (
    .req_i (bus.in_req),
    .op_o  (req_op),
    .bad_o (req_bad)
  );

`ifdef PKT_ENC_CHKSUM_EN
  function automatic logic [3:0] chksum(opcode_e op, logic [PAYLOAD_W-1:0] p);
    logic [3:0] acc;
    acc = 4'(op);
    for (int i = 0; i < NIB; i++) acc = acc ^ p[i*NIBBLE_W +: NIBBLE_W];
    return acc;
  endfunction
`endif

  assign pay_nib  = 4'(pay_q >> {beat_q, 2'b00});
  assign last_nib = (beat_q == LAST_BEAT);

  // Outputs are decoded from registered state only, so they hold naturally under back-pressure.
  always_comb begin
    bus.in_ready = (state_q == IDLE);
    bus.tx_valid = (state_q != IDLE);
    bus.tx_data  = 4'h0;
    bus.tx_last  = 1'b0;
    case (state_q)
      HDR: bus.tx_data = 4'(op_q);
      PAY: begin
        bus.tx_data = pay_nib;
`ifndef PKT_ENC_CHKSUM_EN
        bus.tx_last = last_nib;
`endif
      end
`ifdef PKT_ENC_CHKSUM_EN
      CHK: begin
        bus.tx_data = chksum(op_q, pay_q);
        bus.tx_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.enc_err = err_q;
  assign bus.pkt_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pay_d   = pay_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        op_d    = req_op;
        pay_d   = bus.in_payload;
        err_d   = req_bad;
        state_d = HDR;
      end
      HDR: if (bus.tx_ready) begin
        beat_d  = '0;
        state_d = PAY;
      end
      PAY: if (bus.tx_ready) begin
        if (last_nib) begin
`ifdef PKT_ENC_CHKSUM_EN
          state_d = CHK;
`else
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
`endif
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
`ifdef PKT_ENC_CHKSUM_EN
      CHK: if (bus.tx_ready) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured opcode/payload are only observed outside IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    pay_q <= pay_d;
  end

endmodule

// File: tb/tb_pkt_encoder.sv
// Scoreboard bench for pkt_encoder; expected beats include the checksum when PKT_ENC_CHKSUM_EN is defined.
module tb_pkt_encoder;

  localparam int PW  = 8;
  localparam int CW  = 8;
  localparam int NIB = PW / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pkt_encoder_if #(.PAYLOAD_W(PW), .CNT_W(CW)) bus ();

  pkt_encoder #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_hdr(input logic [4:0] req);
    if ($countones(req) != 1) return 4'd4;
    for (int i = 0; i < 5; i++) if (req[i]) return 4'(i);
    return 4'd4;
  endfunction

  task automatic push_pkt(input logic [4:0] req, input logic [PW-1:0] pay);
    logic [3:0] h;
    logic [3:0] x;
    logic [3:0] n;
    logic       l;
    h = model_hdr(req);
    x = h;
    exp_q.push_back({1'b0, h});
    for (int k = 0; k < NIB; k++) begin
      n = pay[k*4 +: 4];
      x = x ^ n;
`ifdef PKT_ENC_CHKSUM_EN
      l = 1'b0;
`else
      l = (k == NIB - 1);
`endif
      exp_q.push_back({l, n});
    end
`ifdef PKT_ENC_CHKSUM_EN
    exp_q.push_back({1'b1, x});
`endif
  endtask

  // Scoreboard: every accepted beat must match the next expected {last, data}.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst === 1'b0 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_beat: observed data %0h last %0b, expected no beat", bus.tx_data, bus.tx_last);
      end else begin
        e = exp_q.pop_front();
        check("beat", {27'b0, bus.tx_last, bus.tx_data}, {27'b0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns at the negedge of the header cycle.
  task automatic start(input logic [4:0] req, input logic [PW-1:0] pay, input logic exp_err);
    int n;
    tick();
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 32) begin
      tick();
      n++;
    end
    if (n >= 32) begin
      checks++;
      errors++;
      $error("FAIL in_ready_timeout: observed %0b expected 1", bus.in_ready);
    end
    push_pkt(req, pay);
    bus.in_valid   = 1'b1;
    bus.in_req     = req;
    bus.in_payload = pay;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("enc_err_pulse", {31'b0, bus.enc_err}, {31'b0, exp_err});
    check("first_beat_valid", {31'b0, bus.tx_valid}, 32'd1);
    check("hdr_code", {28'b0, bus.tx_data}, {28'b0, model_hdr(req)});
    check("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.tx_valid === 1'b0) return;
    end
    checks++;
    errors++;
    $error("FAIL %s_timeout: observed %0d beats pending expected 0", tag, exp_q.size());
    exp_q.delete();
  endtask

  logic [4:0]    reqs[3];
  logic [PW-1:0] pays[3];
  int idx, idle_run, ngap;
  logic seen, cap;

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_req     = 5'b0;
    bus.in_payload = '0;
    bus.tx_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    check("rst_tx_data",  {28'b0, bus.tx_data}, 32'd0);
    check("rst_tx_last",  {31'b0, bus.tx_last}, 32'd0);
    check("rst_enc_err",  {31'b0, bus.enc_err}, 32'd0);
    check("rst_pkt_cnt",  {24'b0, bus.pkt_cnt}, 32'd0);
    tick();
    rst = 1'b0;

    // JUMP packet
    start(5'b00100, 8'hA5, 1'b0);
    wait_done("jump");
    check("cnt_after_jump", {24'b0, bus.pkt_cnt}, 32'd1);

    // Back-pressure on the first payload nibble
    start(5'b00100, 8'hA5, 1'b0);
    tick();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data",     {28'b0, bus.tx_data}, 32'h5);
      check("stall_valid",    {31'b0, bus.tx_valid}, 32'd1);
      check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      tick();
    end
    bus.tx_ready = 1'b1;
    wait_done("stall");
    check("cnt_after_stall", {24'b0, bus.pkt_cnt}, 32'd2);

    // Malformed and explicit INVALID requests
    start(5'b00110, 8'h3C, 1'b1);
    @(negedge clk);
    check("enc_err_drop", {31'b0, bus.enc_err}, 32'd0);
    wait_done("multi_hot");
    start(5'b00000, 8'h77, 1'b1);
    wait_done("zero_hot");
    start(5'b10000, 8'h5E, 1'b0);
    wait_done("invalid_req");
    check("cnt_after_bad", {24'b0, bus.pkt_cnt}, 32'd5);

    // Back-to-back with in_valid held high
    reqs = '{5'b00001, 5'b00010, 5'b01000};
    pays = '{8'h12, 8'h34, 8'h56};
    for (int i = 0; i < 3; i++) push_pkt(reqs[i], pays[i]);
    tick();
    bus.in_valid   = 1'b1;
    bus.in_req     = reqs[0];
    bus.in_payload = pays[0];
    idx = 0; idle_run = 0; ngap = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (idx == 3 && exp_q.size() == 0 && bus.tx_valid === 1'b0) break;
      cap = bus.in_valid & bus.in_ready;
      if (bus.tx_valid === 1'b1) begin
        if (seen && idle_run > 0) begin
          check("b2b_gap", idle_run, 32'd1);
          ngap++;
        end
        seen = 1'b1;
        idle_run = 0;
      end else if (seen) begin
        idle_run++;
      end
      tick();
      if (cap) begin
        idx++;
        if (idx < 3) begin
          bus.in_req     = reqs[idx];
          bus.in_payload = pays[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    wait_done("b2b");
    check("b2b_captures", idx, 32'd3);
    check("b2b_gaps", ngap, 32'd2);
    check("cnt_after_b2b", {24'b0, bus.pkt_cnt}, 32'd8);

    // Reset during the payload phase
    start(5'b01000, 8'h9F, 1'b0);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    check("abort_tx_last",  {31'b0, bus.tx_last}, 32'd0);
    check("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("abort_pkt_cnt",  {24'b0, bus.pkt_cnt}, 32'd0);

    // Counter wrap
    for (int i = 0; i < 256; i++) begin
      start(5'b00001, 8'(i), 1'b0);
      wait_done("wrap");
    end
    check("cnt_wrap_256", {24'b0, bus.pkt_cnt}, 32'd0);
    start(5'b00010, 8'hC3, 1'b0);
    wait_done("wrap_257");
    check("cnt_wrap_257", {24'b0, bus.pkt_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_encoder.md
Name: pkt_encoder

Overview:
- Transmit-side counterpart of the packet decoder.
- Accepts a one-hot operation request plus payload and encodes the request into the 4-bit info code.
- Serialises the packet as a header nibble followed by payload nibbles over a valid/ready nibble stream.
- Sits between the instruction-issue logic and the packet link; its output feeds the decoder's info input.

Parameters:
- PAYLOAD_W, 8, payload width in bits; must be a multiple of 4 and at least 4; the number of payload nibbles is PAYLOAD_W/4.
- CNT_W, 8, width of the sent-packet counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request.
- in_req  input  5  one-hot request: bit0 LOAD, bit1 STORE, bit2 JUMP, bit3 ALU_OP, bit4 INVALID.
- in_payload  input  PAYLOAD_W  payload data.
- tx_valid  output  1  nibble valid.
- tx_ready  input  1  sink accepts the nibble.
- tx_data  output  4  header, payload or checksum nibble.
- tx_last  output  1  marks the final nibble of the packet.
- enc_err  output  1  one-cycle pulse when a malformed request is captured.
- pkt_cnt  output  CNT_W  count of completed packets.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - in_ready=1.
  - tx_valid=0, tx_data=0, tx_last=0.
  - enc_err=0, pkt_cnt=0.
  - FSM in IDLE.
- FSM states: IDLE, HDR, PAY, CHK (CHK exists only with the optional feature).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register the opcode and payload, then go to HDR.
  - tx_valid rises in the following cycle, so capture-to-first-beat latency is 1 cycle.
- Encoding, info code on header tx_data:
  - LOAD=0, STORE=1, JUMP=2, ALU_OP=3, INVALID=4.
  - An in_req that is not exactly one-hot (zero bits or more than one bit set) encodes to INVALID.
  - Such a request also pulses enc_err for exactly the cycle after capture.
  - in_req=5'b10000 encodes to INVALID with no enc_err.
- HDR: tx_valid=1, tx_data=info code. On tx_valid&&tx_ready, go to PAY with beat counter=0.
- PAY:
  - tx_data = payload nibble [4*k+3:4*k], where k is the beat counter; least significant nibble first.
  - Each accepted beat increments k.
  - On the last nibble (k==PAYLOAD_W/4-1), tx_last=1 unless the optional feature is enabled.
- Stall rule: while tx_valid && !tx_ready, tx_data, tx_last and the state hold unchanged.
- Packet completion:
  - Completion is acceptance of the beat with tx_last=1.
  - pkt_cnt increments by 1 and wraps from 2^CNT_W-1 to 0.
  - The FSM returns to IDLE with tx_valid=0.
- Inter-packet gap: in_ready is 0 from HDR through completion and rises in the cycle after completion, giving a mandatory 1-cycle bubble between packets.
- Input stability: in_valid held while in_ready=0 is ignored; no queueing.
- Reset mid-packet: the packet is aborted without tx_last, all outputs return to reset values in the next cycle, and pkt_cnt is cleared.

Optional Feature:
- Macro: PKT_ENC_CHKSUM_EN.
- Defined:
  - After the last payload nibble, the FSM enters CHK.
  - CHK sends the XOR of the header and all payload nibbles, with tx_last=1 on that beat only.
  - Packet length is PAYLOAD_W/4+2 beats.
- Undefined:
  - There is no CHK state and tx_last sits on the last payload nibble.
  - Packet length is PAYLOAD_W/4+1 beats.

Decomposition:
- Package pkt_pkg holds:
  - typedef enum logic [3:0] opcode_e {LOAD=0, STORE=1, JUMP=2, ALU_OP=3, INVALID=4}.
  - The FSM state typedef.
  - Constants OP_NUM=5 and NIBBLE_W=4.
  - The decoder is to import the same opcode_e.
- Sub-module pkt_onehot_enc: combinational in_req[4:0] to {opcode_e, malformed flag}. It is instantiated once.

Test Plan:
- JUMP packet: PAYLOAD_W=8, in_req=5'b00100, in_payload=8'hA5, tx_ready=1.
  - Beats: tx_data 2, 5, A, with tx_last on A.
  - pkt_cnt becomes 1.
  - With PKT_ENC_CHKSUM_EN the beats are 2, 5, A, D, with tx_last on D.
- Back-pressure: same request with tx_ready=0 for 3 cycles during the second beat.
  - tx_data is held at 5 and tx_valid stays 1.
  - Sequence is unchanged after release.
  - in_ready stays 0 throughout.
- Malformed requests: in_req=5'b00110, payload 8'h3C.
  - Header 4, enc_err high for 1 cycle, beats 4, C, 3.
  - in_req=5'b00000 also yields header 4 with enc_err.
- All opcodes back to back with in_valid held high and tx_ready=1.
  - Request sequence LOAD, STORE, ALU_OP gives headers 0, 1, 3.
  - Exactly one idle cycle with tx_valid=0 separates each packet.
- Reset mid-packet: assert rst for 1 cycle during PAY.
  - Next cycle shows tx_valid=0, in_ready=1, pkt_cnt=0, and no tx_last was emitted.
- Counter wrap: send 256 packets with CNT_W=8.
  - pkt_cnt reads 0 after the 256th packet and 1 after the 257th.
